// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program sequencer issuing one {imm,instr} word per clock to the execute stage
// Idle and stalled cycles present the MOV A,A bubble because the execute stage has no valid input.
module instr_fetch_unit #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stall,
  output logic [7:0]    instr,
  output logic [7:0]    in_data,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, RUN} state_t;
  localparam int LW = AW + 1;
  localparam logic [7:0] BUBBLE = 8'h80;

  logic [15:0]   mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    instr_q, instr_d;
  logic [7:0]    in_data_q, in_data_d;
  logic          instr_valid_q, instr_valid_d;
  logic          done_q, done_d;

  logic [15:0]   rd_word;
  logic [AW:0]   len_clamp;
  logic          last_word;

  // Program memory is deliberately not reset so a reset mid-run keeps the program.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == IDLE) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign rd_word   = mem[pc_q];
  assign len_clamp = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign last_word = ({1'b0, pc_q} == (len_q - LW'(1)));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    pc_d          = pc_q;
    instr_d       = BUBBLE;
    in_data_d     = in_data_q;
    instr_valid_d = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_clamp != '0) begin
            state_d = RUN;
            len_d   = len_clamp;
            pc_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          instr_d       = rd_word[7:0];
          in_data_d     = rd_word[15:8];
          instr_valid_d = 1'b1;
          if (last_word) begin
            done_d  = 1'b1;
            state_d = IDLE;
            pc_d    = '0;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      pc_q          <= '0;
      instr_q       <= BUBBLE;
      in_data_q     <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      in_data_q     <= in_data_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
    end
  end

  assign instr       = instr_q;
  assign in_data     = in_data_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [15:0] prog_data;
  logic [5:0] prog_len;
  logic       start;
  logic       stall;
  logic [7:0] instr;
  logic [7:0] in_data;
  logic       instr_valid;
  logic [4:0] pc;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(.DEPTH(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .stall(stall),
    .instr(instr), .in_data(in_data), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; stall = 1'b0;
    #1;
    n_cmp++;
    if ({instr, instr_valid, pc, busy, done} !== {8'h80, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async: instr=%h valid=%b pc=%0d busy=%b done=%b, need 80/0/0/0/0",
               instr, instr_valid, pc, busy, done);
    end
    n_cmp++;
    if (in_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_in_data: got %h need 00", in_data);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  // Last word written in the same cycle as start: the run must see it.
  task automatic test_basic();
    load_word(5'd0, 16'h3008);
    load_word(5'd1, 16'h2000);
    prog_we = 1'b1; prog_addr = 5'd2; prog_data = 16'h0041;
    prog_len = 6'd3; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    n_cmp++;
    if ({busy, instr_valid, instr} !== {1'b1, 1'b0, 8'h80}) begin
      n_bad++; $display("FAIL basic_after_start: busy=%b valid=%b instr=%h need 1/0/80", busy, instr_valid, instr);
    end
    step();
    n_cmp++;
    if ({instr, in_data, instr_valid, done} !== {8'h08, 8'h30, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL basic_w0: %h/%h v=%b d=%b need 08/30/1/0", instr, in_data, instr_valid, done);
    end
    step();
    n_cmp++;
    if ({instr, in_data, instr_valid, done} !== {8'h00, 8'h20, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL basic_w1: %h/%h v=%b d=%b need 00/20/1/0", instr, in_data, instr_valid, done);
    end
    step();
    n_cmp++;
    if ({instr, in_data, instr_valid, done} !== {8'h41, 8'h00, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL basic_w2: %h/%h v=%b d=%b need 41/00/1/1", instr, in_data, instr_valid, done);
    end
    step();
    n_cmp++;
    if ({instr, instr_valid, done, busy, pc} !== {8'h80, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      n_bad++; $display("FAIL basic_bubble: instr=%h v=%b d=%b busy=%b pc=%0d need 80/0/0/0/0",
                        instr, instr_valid, done, busy, pc);
    end
  endtask

  task automatic test_stall();
    prog_len = 6'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++;
    if ({instr, in_data, instr_valid} !== {8'h08, 8'h30, 1'b1}) begin
      n_bad++; $display("FAIL stall_w0: %h/%h v=%b need 08/30/1", instr, in_data, instr_valid);
    end
    stall = 1'b1;
    step();
    stall = 1'b0;
    n_cmp++;
    if ({instr, in_data, instr_valid, pc, done} !== {8'h80, 8'h30, 1'b0, 5'd1, 1'b0}) begin
      n_bad++; $display("FAIL stall_bubble: %h/%h v=%b pc=%0d d=%b need 80/30/0/1/0",
                        instr, in_data, instr_valid, pc, done);
    end
    step();
    n_cmp++;
    if ({instr, in_data, instr_valid, done} !== {8'h00, 8'h20, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL stall_w1: %h/%h v=%b d=%b need 00/20/1/0", instr, in_data, instr_valid, done);
    end
    step();
    n_cmp++;
    if ({instr, instr_valid, done} !== {8'h41, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL stall_w2: %h v=%b d=%b need 41/1/1", instr, instr_valid, done);
    end
    step();
    n_cmp++;
    if ({instr_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL stall_end: v=%b busy=%b need 0/0", instr_valid, busy);
    end
  endtask

  task automatic test_zero_len();
    int dones = 0;
    int valids = 0;
    int busys = 0;
    prog_len = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if ({done, busy, instr_valid} !== 3'b100) begin
      n_bad++; $display("FAIL zero_len_pulse: done=%b busy=%b v=%b need 1/0/0", done, busy, instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      dones += int'(done); valids += int'(instr_valid); busys += int'(busy);
    end
    n_cmp++;
    if ({dones, valids, busys} !== {32'd0, 32'd0, 32'd0}) begin
      n_bad++; $display("FAIL zero_len_after: done=%0d valid=%0d busy=%0d need 0/0/0", dones, valids, busys);
    end
  endtask

  task automatic test_clamp();
    int nvalid = 0;
    int ndone = 0;
    int nwrong = 0;
    for (int i = 0; i < 32; i++) begin
      load_word(5'(i), {8'(8'hC0 - i), 8'(8'h40 + i)});
    end
    prog_len = 6'd40; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 45; c++) begin
      step();
      if (instr_valid) begin
        if ({in_data, instr} !== {8'(8'hC0 - nvalid), 8'(8'h40 + nvalid)}) nwrong++;
        nvalid++;
      end
      ndone += int'(done);
    end
    n_cmp++;
    if (nvalid !== 32) begin
      n_bad++; $display("FAIL clamp_count: got %0d valid words need 32", nvalid);
    end
    n_cmp++;
    if (nwrong !== 0) begin
      n_bad++; $display("FAIL clamp_data: %0d wrong words need 0", nwrong);
    end
    n_cmp++;
    if ({ndone, pc, busy} !== {32'd1, 5'd0, 1'b0}) begin
      n_bad++; $display("FAIL clamp_end: done=%0d pc=%0d busy=%b need 1/0/0", ndone, pc, busy);
    end
  endtask

  task automatic test_reset_midrun();
    prog_len = 6'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_cmp++;
    if ({instr, instr_valid} !== {8'h41, 1'b1}) begin
      n_bad++; $display("FAIL midrun_w1: %h v=%b need 41/1", instr, instr_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({instr, instr_valid, pc, busy, done} !== {8'h80, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL midrun_reset: instr=%h v=%b pc=%0d busy=%b done=%b need 80/0/0/0/0",
                        instr, instr_valid, pc, busy, done);
    end
    step();
    rst = 1'b0;
    step();
    prog_len = 6'd3; start = 1'b1;
    step();
    start = 1'b0;
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 16'hDEAD;
    step();
    prog_we = 1'b0;
    n_cmp++;
    if ({instr, in_data} !== {8'h40, 8'hC0}) begin
      n_bad++; $display("FAIL replay_w0: %h/%h need 40/C0", instr, in_data);
    end
    step();
    n_cmp++;
    if ({instr, in_data} !== {8'h41, 8'hBF}) begin
      n_bad++; $display("FAIL replay_w1: %h/%h need 41/BF", instr, in_data);
    end
    step();
    n_cmp++;
    if ({instr, in_data, done} !== {8'h42, 8'hBE, 1'b1}) begin
      n_bad++; $display("FAIL replay_w2: %h/%h d=%b need 42/BE/1", instr, in_data, done);
    end
    step();
    prog_len = 6'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_cmp++;
    if ({instr, in_data} !== {8'h41, 8'hBF}) begin
      n_bad++; $display("FAIL run_write_ignored: %h/%h need 41/BF", instr, in_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_clamp();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
